ebus_master: RTL and testbench

EBOX-side EBUS master sequencer: executes one CONO/CONI/DATAO/DATAI transfer per request, from arbitration through the demand/transfer handshake. Responders such as the APR watch controller select, function, and demand on the bus, then answer with transfer and, for reads, data. Sits between the EBOX I/O instruction control and the shared EBUS; one transfer is outstanding at a time.

---
 rtl/ebus_pkg.sv | 30 +++
 rtl/ebus_timeout.sv | 31 +++
 rtl/ebus_master.sv | 175 +++++++++++++++++
 tb/tb_ebus_master.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ebus_pkg.sv
// ebus_pkg: shared EBUS definitions. Function codes are imported by the
// master and by every responder so both sides agree on the encoding.
package ebus_pkg;

    // EBUS function codes; 4-7 are reserved and rejected by the master.
    localparam logic [0:2] EBUS_CONO  = 3'd0;
    localparam logic [0:2] EBUS_CONI  = 3'd1;
    localparam logic [0:2] EBUS_DATAO = 3'd2;
    localparam logic [0:2] EBUS_DATAI = 3'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_SETUP,
        S_DEMAND,
        S_RELEASE,
        S_DONE
    } ebusState_e;

    // Reads take data from the responder; the master never drives the lines.
    function automatic logic isRead(input logic [0:2] func);
        return (func == EBUS_CONI) || (func == EBUS_DATAI);
    endfunction

    // Bit 0 is the MSB in EBUS numbering, so it marks codes 4-7.
    function automatic logic isReserved(input logic [0:2] func);
        return func[0];
    endfunction

endpackage

// File: rtl/ebus_timeout.sv
// ebus_timeout: loadable down-counter that stops at zero. Used by the
// master to time CS/F setup and to bound the demand/release wait.
module ebus_timeout #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             load,
    input  logic [WIDTH-1:0] loadValue,
    input  logic             enable,
    output logic             expired
);

    logic [WIDTH-1:0] count;

    // Load wins over counting; the count parks at zero until reloaded.
    always_ff @(posedge clk) begin
        // NOTE: all sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!resetN) begin
            count <= '0;
        end else if (load) begin
            count <= loadValue;
        end else if (enable && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/ebus_master.sv
// ebus_master: EBOX-side EBUS sequencer, one CONO/CONI/DATAO/DATAI transfer
// per start pulse: request, CS/F setup, demand, transfer, release.
// Optional feature: define EBUS_TIMEOUT_EN to abort a transfer whose
// responder does not finish the handshake within TIMEOUT_CYCLES.
module ebus_master
    import ebus_pkg::*;
#(
    parameter int SETUP_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        start,
    input  logic [0:6]  cs,
    input  logic [0:2]  func,
    input  logic [0:35] wrData,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [0:35] rdData,
    output logic        ebusReq,
    input  logic        ebusGrant,
    output logic [0:6]  ebusCS,
    output logic [0:2]  ebusF,
    output logic        ebusDemand,
    input  logic        ebusXfer,
    output logic        ebusDriveEn,
    output logic [0:35] EBUS_OUT,
    input  logic [0:35] EBUS
);

    if (SETUP_CYCLES < 1 || TIMEOUT_CYCLES < 2) begin : gBadParams
        $error("ebus_master: need SETUP_CYCLES >= 1 and TIMEOUT_CYCLES >= 2");
    end

    // Setup counter holds SETUP_CYCLES-1 so DEMAND follows after exactly
    // SETUP_CYCLES cycles in SETUP.
    localparam int SETUP_W = $clog2(SETUP_CYCLES + 1);
    localparam logic [SETUP_W-1:0] SETUP_LOAD = SETUP_W'(SETUP_CYCLES - 1);

    ebusState_e  state;
    logic [0:6]  latCS;
    logic [0:2]  latFunc;
    logic [0:35] latData;
    logic        setupLoad;
    logic        setupExpired;
    logic        timeoutHit;

    assign setupLoad = (state == S_REQ) && ebusGrant;

    ebus_timeout #(.WIDTH(SETUP_W)) uSetup (
        .clk       (clk),
        .resetN    (resetN),
        .load      (setupLoad),
        .loadValue (SETUP_LOAD),
        .enable    (state == S_SETUP),
        .expired   (setupExpired)
    );

`ifdef EBUS_TIMEOUT_EN
    // Counts TIMEOUT_CYCLES-1 down to zero across DEMAND and RELEASE; the
    // abort fires on the edge that would be the TIMEOUT_CYCLES-th wait cycle.
    localparam int TO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYCLES - 1);

    logic inWait;
    logic enterDemand;
    logic toExpired;

    assign inWait      = (state == S_DEMAND) || (state == S_RELEASE);
    assign enterDemand = (state == S_SETUP) && ebusGrant && setupExpired;

    ebus_timeout #(.WIDTH(TO_W)) uTimeout (
        .clk       (clk),
        .resetN    (resetN),
        .load      (enterDemand),
        .loadValue (TO_LOAD),
        .enable    (inWait),
        .expired   (toExpired)
    );

    assign timeoutHit = inWait && toExpired;
`else
    assign timeoutHit = 1'b0;
`endif

    // Sequencer: state and every output register updated on the same edge.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state       <= S_IDLE;
            latCS       <= '0;
            latFunc     <= '0;
            latData     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            rdData      <= '0;
            ebusReq     <= 1'b0;
            ebusCS      <= '0;
            ebusF       <= '0;
            ebusDemand  <= 1'b0;
            ebusDriveEn <= 1'b0;
            EBUS_OUT    <= '0;
        end else begin
            // NOTE: done/err default low here so they pulse for exactly the
            // one edge that sets them, without per-state clearing.
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        latCS   <= cs;
                        latFunc <= func;
                        latData <= wrData;
                        busy    <= 1'b1;
                        if (isReserved(func)) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            state   <= S_REQ;
                            ebusReq <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    if (ebusGrant) begin
                        state       <= S_SETUP;
                        ebusCS      <= latCS;
                        ebusF       <= latFunc;
                        ebusDriveEn <= !isRead(latFunc);
                        EBUS_OUT    <= isRead(latFunc) ? '0 : latData;
                    end
                end
                S_SETUP: begin
                    if (!ebusGrant) begin
                        state       <= S_REQ;
                        ebusCS      <= '0;
                        ebusF       <= '0;
                        ebusDriveEn <= 1'b0;
                        EBUS_OUT    <= '0;
                    end else if (setupExpired) begin
                        state      <= S_DEMAND;
                        ebusDemand <= 1'b1;
                    end
                end
                S_DEMAND, S_RELEASE: begin
                    if (timeoutHit || (state == S_RELEASE && !ebusXfer)) begin
                        state       <= S_DONE;
                        done        <= 1'b1;
                        err         <= timeoutHit;
                        ebusReq     <= 1'b0;
                        ebusDemand  <= 1'b0;
                        ebusCS      <= '0;
                        ebusF       <= '0;
                        ebusDriveEn <= 1'b0;
                        EBUS_OUT    <= '0;
                    end else if (state == S_DEMAND && ebusXfer) begin
                        state      <= S_RELEASE;
                        ebusDemand <= 1'b0;
                        if (isRead(latFunc)) begin
                            rdData <= EBUS;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ebus_master.sv
// tb_ebus_master: directed transfers against a schedule-level model.
// k counts rising edges from the edge that samples start (k=0); outputs
// are compared on the falling edge after edge k.
module tb_ebus_master;
    import ebus_pkg::*;

    localparam int SETUP = 2;
    localparam int TOUT  = 16;
    localparam int MAXK  = 128;
    localparam int NEVER = 100000;
`ifdef EBUS_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        err;
        logic [35:0] rd;
        logic        req;
        logic [6:0]  cs;
        logic [2:0]  f;
        logic        dem;
        logic        drv;
        logic [35:0] out;
    } outs_t;

    logic        clk;
    logic        resetN;
    logic        start;
    logic [6:0]  cs;
    logic [2:0]  func;
    logic [35:0] wrData;
    logic        ebusGrant;
    logic        ebusXfer;
    logic [35:0] ebusData;
    logic        busy, done, err, ebusReq, ebusDemand, ebusDriveEn;
    logic [35:0] rdData, ebusOut;
    logic [6:0]  ebusCS;
    logic [2:0]  ebusF;

    ebus_master #(.SETUP_CYCLES(SETUP), .TIMEOUT_CYCLES(TOUT)) dut (
        .clk         (clk),
        .resetN      (resetN),
        .start       (start),
        .cs          (cs),
        .func        (func),
        .wrData      (wrData),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .rdData      (rdData),
        .ebusReq     (ebusReq),
        .ebusGrant   (ebusGrant),
        .ebusCS      (ebusCS),
        .ebusF       (ebusF),
        .ebusDemand  (ebusDemand),
        .ebusXfer    (ebusXfer),
        .ebusDriveEn (ebusDriveEn),
        .EBUS_OUT    (ebusOut),
        .EBUS        (ebusData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int curK     = 0;
    bit chkEn    = 1'b0;

    // Transaction plan: input schedules plus the milestones derived from them.
    bit          grantV [MAXK];
    bit          xferV  [MAXK];
    logic [2:0]  pFunc;
    logic [6:0]  pCS;
    logic [35:0] pData, pBus, rdPrev;
    int          rstAt, gK, dK, xK, rK, eK;
    bit          reserved, rd, timedOut, capture;
    int          firstDoneK;
    bit          sawReq, sawDrive;
    outs_t       expNow;

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s k=%0d actual=%0o required=%0o", name, curK, act, exp);
        end
    endtask

    task automatic checkInt(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Milestones: setup starts at the first edge opening an unbroken run of
    // SETUP+1 granted edges; demand follows SETUP edges later; the first
    // xfer after that acknowledges; the first xfer-low after that ends it.
    function automatic void computePlan();
        bit ok;
        reserved = (pFunc >= 3'd4);
        rd       = (pFunc == 3'd1) || (pFunc == 3'd3);
        gK = NEVER; dK = NEVER; xK = NEVER; rK = NEVER;
        for (int k = 1; k + SETUP < MAXK; k++) begin
            ok = 1'b1;
            for (int j = 0; j <= SETUP; j++) if (!grantV[k + j]) ok = 1'b0;
            if (ok && gK == NEVER) gK = k;
        end
        if (gK != NEVER) dK = gK + SETUP;
        for (int k = 0; k < MAXK; k++) if (k > dK && xferV[k] && xK == NEVER) xK = k;
        for (int k = 0; k < MAXK; k++) if (k > xK && !xferV[k] && rK == NEVER) rK = k;
        eK = rK;
        timedOut = 1'b0;
        if (TIMEOUT_ON && dK != NEVER && rK >= dK + TOUT) begin
            eK = dK + TOUT;
            timedOut = 1'b1;
        end
        if (reserved) begin
            eK = 0;
            timedOut = 1'b0;
        end
        capture = !reserved && rd && (xK < eK);
    endfunction

    function automatic outs_t expAt(input int k);
        outs_t o;
        o = '0;
        if (rstAt >= 0 && k >= rstAt) return o;
        o.rd = (capture && k >= xK) ? pBus : rdPrev;
        if (reserved) begin
            if (k == 0) begin
                o.busy = 1'b1;
                o.done = 1'b1;
                o.err  = 1'b1;
            end
            return o;
        end
        if (k > eK) return o;
        o.busy = 1'b1;
        if (k == eK) begin
            o.done = 1'b1;
            o.err  = timedOut;
            return o;
        end
        o.req = 1'b1;
        if ((k >= 1 && k < dK && grantV[k]) || k >= dK) begin
            o.cs  = pCS;
            o.f   = pFunc;
            o.drv = !rd;
            o.out = rd ? 36'o0 : pData;
        end
        o.dem = (k >= dK) && (k < xK);
        return o;
    endfunction

    // Single compare point for every transaction cycle.
    always @(negedge clk) begin
        if (chkEn) begin
            expNow = expAt(curK);
            check("busy",       busy,        expNow.busy);
            check("done",       done,        expNow.done);
            check("err",        err,         expNow.err);
            check("rdData",     rdData,      expNow.rd);
            check("ebusReq",    ebusReq,     expNow.req);
            check("ebusCS",     ebusCS,      expNow.cs);
            check("ebusF",      ebusF,       expNow.f);
            check("ebusDemand", ebusDemand,  expNow.dem);
            check("ebusDriveEn",ebusDriveEn, expNow.drv);
            check("EBUS_OUT",   ebusOut,     expNow.out);
            if (done && firstDoneK < 0) firstDoneK = curK;
            if (ebusReq) sawReq = 1'b1;
            if (ebusDriveEn) sawDrive = 1'b1;
        end
    end

    task automatic setGrant(input int lo, input int hi);
        for (int k = lo; k <= hi; k++) grantV[k] = 1'b1;
    endtask

    task automatic setXfer(input int lo, input int hi);
        for (int k = lo; k <= hi; k++) xferV[k] = 1'b1;
    endtask

    task automatic doReset();
        chkEn = 1'b0;
        resetN = 1'b0; start = 1'b0; ebusGrant = 1'b0; ebusXfer = 1'b0;
        cs = '0; func = '0; wrData = '0; ebusData = '0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check("rst busy", busy, 0);        check("rst done", done, 0);
        check("rst err", err, 0);          check("rst rdData", rdData, 0);
        check("rst ebusReq", ebusReq, 0);  check("rst ebusCS", ebusCS, 0);
        check("rst ebusF", ebusF, 0);      check("rst ebusDemand", ebusDemand, 0);
        check("rst ebusDriveEn", ebusDriveEn, 0);
        check("rst EBUS_OUT", ebusOut, 0);
        resetN = 1'b1;
        rdPrev = '0;
        @(posedge clk);
        @(negedge clk); #1;
    endtask

    task automatic runTxn(input string name, input logic [2:0] f, input logic [6:0] c,
                          input logic [35:0] d, input logic [35:0] bus, input int rAt,
                          input int spur, input int expDone);
        int lastK;
        pFunc = f; pCS = c; pData = d; pBus = bus; rstAt = rAt;
        computePlan();
        if (rAt >= 0) lastK = rAt + 1;
        else if (eK < MAXK - 3) lastK = eK + 2;
        else lastK = MAXK - 1;
        firstDoneK = -1; sawReq = 1'b0; sawDrive = 1'b0;
        ebusData = bus;
        for (int k = 0; k <= lastK; k++) begin
            start     = (k == 0) || (k == spur);
            cs        = (k == 0) ? c : 7'o177;
            func      = (k == 0) ? f : 3'd3;
            wrData    = (k == 0) ? d : 36'o707070707070;
            ebusGrant = grantV[k];
            ebusXfer  = xferV[k];
            resetN    = (k != rAt);
            @(posedge clk);
            curK  = k;
            chkEn = 1'b1;
            @(negedge clk); #1;
        end
        chkEn = 1'b0;
        start = 1'b0; ebusGrant = 1'b0; ebusXfer = 1'b0; resetN = 1'b1;
        checkInt({name, " done edge"}, firstDoneK, expDone);
        if (rAt >= 0) rdPrev = '0;
        else if (capture) rdPrev = bus;
        for (int k = 0; k < MAXK; k++) begin
            grantV[k] = 1'b0;
            xferV[k]  = 1'b0;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at k=%0d", curK);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < MAXK; k++) begin
            grantV[k] = 1'b0;
            xferV[k]  = 1'b0;
        end
        rdPrev = '0;
        rstAt  = -1;
        doReset();

        // Best-case DATAO; a start during the DONE cycle must be ignored.
        setGrant(0, MAXK - 1); setXfer(4, 4);
        runTxn("datao", EBUS_DATAO, 7'o4, 36'o123456701234, 36'o555555555555, -1, 6, 5);

        // DATAI capture; a start while in SETUP must be ignored.
        setGrant(0, MAXK - 1); setXfer(4, 4);
        runTxn("datai", EBUS_DATAI, 7'o4, 36'o0, 36'o777000111222, -1, 2, 5);
        check("datai rdData held", rdData, 36'o777000111222);
        check("datai never drove", {35'd0, sawDrive}, 36'd0);

        // Reserved function: immediate error completion, no bus request.
        setGrant(0, MAXK - 1);
        runTxn("reserved", 3'd5, 7'o33, 36'o1, 36'o0, -1, -1, 0);
        check("reserved never requested", {35'd0, sawReq}, 36'd0);

        // Grant withheld for edges 0-10.
        setGrant(11, MAXK - 1); setXfer(14, 14);
        runTxn("late grant", EBUS_CONO, 7'o21, 36'o17, 36'o0, -1, -1, 15);

        // Grant drops mid-setup; xfer already high before demand.
        setGrant(1, 2); setGrant(4, MAXK - 1); setXfer(5, 7);
        runTxn("grant drop", EBUS_CONI, 7'o4, 36'o0, 36'o123123123123, -1, -1, 8);
        check("coni rdData", rdData, 36'o123123123123);

        // Responder never answers: timeout abort, or an endless wait cut by reset.
        setGrant(0, MAXK - 1);
        runTxn("no xfer", EBUS_DATAI, 7'o4, 36'o0, 36'o111111111111,
               TIMEOUT_ON ? -1 : 30, -1, TIMEOUT_ON ? 19 : -1);
        check("no xfer rdData", rdData, TIMEOUT_ON ? 36'o123123123123 : 36'o0);

        // Reset while in DEMAND abandons the transfer.
        setGrant(0, MAXK - 1);
        runTxn("reset in demand", EBUS_DATAO, 7'o4, 36'o42, 36'o0, 5, -1, -1);

        // Normal transfer after reset.
        setGrant(0, MAXK - 1); setXfer(4, 4);
        runTxn("after reset", EBUS_CONO, 7'o7, 36'o765432107654, 36'o0, -1, -1, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
